// File: rtl/digit_scan.sv
// Scan controller for a multiplexed 7-segment display: walks the digit
// slots, blanks the start of each slot and shows a frame-stable snapshot.
module digit_scan #(
    parameter int NUM_DIGITS = 6,
    parameter int DIV        = 50000,
    parameter int BLANK      = 500
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic [3:0]                bcd_pos,
    output logic [3:0]                bcd_digit,
    output logic                      dp,
    output logic                      frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    localparam logic [2:0]    POS_MAX = 3'(NUM_DIGITS - 1);

    logic [CW-1:0]                cnt;
    logic [2:0]                   pos;
    logic [NUM_DIGITS-1:0][3:0]   shadow_d;
    logic [NUM_DIGITS-1:0]        shadow_dp;

    logic slot_end;
    logic frame_end;
    logic blank;

    assign slot_end  = en && (cnt == CNT_MAX);
    assign frame_end = slot_end && (pos == POS_MAX);
    assign blank     = !en || (cnt < BLANK_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            pos        <= '0;
            shadow_d   <= '0;
            shadow_dp  <= '0;
            bcd_pos    <= 4'hF;
            bcd_digit  <= 4'h0;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            if (!en) begin
                cnt <= '0;
                pos <= '0;
            end else if (slot_end) begin
                cnt <= '0;
                pos <= (pos == POS_MAX) ? 3'd0 : pos + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Snapshot only between frames so a frame never tears.
            if (!en || frame_end) begin
                shadow_d  <= digits;
                shadow_dp <= dp_mask;
            end

            if (blank) begin
                bcd_pos   <= 4'hF;
                bcd_digit <= 4'h0;
                dp        <= 1'b0;
            end else begin
                bcd_pos   <= {1'b0, pos};
                bcd_digit <= shadow_d[pos];
                dp        <= shadow_dp[pos];
            end

            frame_tick <= frame_end;
        end
    end

endmodule
